psw_flag_unit: RTL
==================

Name: psw_flag_unit

Overview:
- Processor-status-word stage directly downstream of the 16-bit ALU.
- Registers the ALU's N/Z/C/V outputs under a per-flag write mask and feeds the registered C back to the ALU carry-in for add/subtract-with-carry.
- Evaluates a 4-bit branch condition code against the registered flags.
- Holds a small LIFO of saved flag sets for interrupt/call save and restore.

Parameters:
- STACK_DEPTH, 4, number of saved flag sets in the LIFO; legal range 2..16.
- CNT_W, $clog2(STACK_DEPTH+1), width of the occupancy count; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_n  in  1  ALU negative flag.
- alu_z  in  1  ALU zero flag.
- alu_c  in  1  ALU carry flag.
- alu_v  in  1  ALU overflow flag.
- flag_we  in  4  per-flag write enable; bit3=N, bit2=Z, bit1=C, bit0=V.
- cond  in  4  branch condition code.
- push  in  1  save current flags to LIFO.
- pop  in  1  restore flags from LIFO.
- err_clr  in  1  clear sticky error bits.
- flags  out  4  registered {N,Z,C,V}.
- cin  out  1  carry into the ALU; equals flags[1].
- cond_true  out  1  selected condition holds on the registered flags.
- depth  out  CNT_W  LIFO occupancy.
- full  out  1  depth == STACK_DEPTH.
- empty  out  1  depth == 0.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, rst_n low): flags=4'b0000, depth=0, ovf_err=0, unf_err=0, LIFO contents don't-care. Combinational outputs follow: cin=0, empty=1, full=0.
- Flag update, rising edge: each flag with flag_we bit set loads its alu_* input; unmasked flags hold. One-cycle latency; the new value is visible on flags/cin/cond_true the cycle after the write.
- cond_true is purely combinational from the registered flags, with no bypass of alu_* inputs:
  - 0 EQ: Z. 1 NE: ~Z.
  - 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N.
  - 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - 10 GE: N==V. 11 LT: N!=V.
  - 12 GT: ~Z&(N==V). 13 LE: Z|(N!=V).
  - 14 AL: 1. 15 NV: 0.
- Push (push=1, pop=0):
  - Not full: writes the pre-update flags to LIFO[depth], depth+1.
  - Full: push dropped, depth held, ovf_err set.
- Pop (pop=1, push=0):
  - Not empty: flags load LIFO[depth-1], depth-1. Pop overrides flag_we for all four flags.
  - Empty: flags follow flag_we normally, depth held, unf_err set.
- push=1 and pop=1 in the same cycle: stack no-op, depth held, no error; flag_we applies normally.
- push together with flag_we: the saved value is the old flags; the live flags take the new values.
- err_clr: clears ovf_err and unf_err at the edge. If a new error condition occurs in the same cycle, the set wins.
- Reset mid-operation discards all LIFO state and errors immediately.

Optional Feature:
- Macro: PSW_FLAG_STACK_EN.
- Defined: the LIFO, push/pop, depth/full/empty and ovf/unf errors exist as described above.
- Undefined:
  - No LIFO storage is built; push and pop are ignored.
  - depth=0, empty=1, full=0, ovf_err=0, unf_err=0 constantly.
  - flag_we always governs flag updates.

Decomposition:
- Shared package psw_pkg holds:
  - the condition-code localparams COND_EQ..COND_NV (0..15);
  - flag bit indices FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
- Natural sub-module: cond_eval, purely combinational (4-bit flags, 4-bit cond -> cond_true), reused by the branch unit.
- LIFO storage stays inline.

Test Plan:
- Reset check: hold rst_n=0 mid-stream -> flags=0000, cin=0, depth=0, empty=1, errors 0; cond=14 gives cond_true=1, cond=15 gives 0.
- Masked write: flags=0000; alu NZCV=1111 with flag_we=0011 -> next cycle flags=0011 and cin=1. Then cond=2 -> 1, cond=10 (GE, N=0,V=1) -> 0, cond=11 -> 1.
- Condition sweep: for each of the 16 flag values, step cond 0..15 and compare cond_true against a reference model; all 256 cases must match.
- Stack round-trip, STACK_DEPTH=4: push flags 1000, 0100, 0010, 0001 -> full=1. Fifth push -> ovf_err=1, depth stays 4. Four pops restore 0001, 0010, 0100, 1000 in order; fifth pop -> unf_err=1, flags unchanged.
- Simultaneous events:
  - push with flag_we=1111, alu=1010, flags=0101 -> stack top=0101, flags=1010.
  - pop with flag_we=1111 -> flags=popped value.
  - push+pop together -> depth unchanged, no error.
  - err_clr with a concurrent overflow push -> ovf_err stays 1.
- Macro off (PSW_FLAG_STACK_EN undefined): push/pop toggling -> depth=0, empty=1, errors 0, flags change only via flag_we.

Source files
------------

// File: rtl/psw_pkg.sv
// psw_pkg: shared condition-code encodings and flag bit positions for the PSW flag unit.
package psw_pkg;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
endpackage

// File: rtl/psw_flag_unit_if.sv
// psw_flag_unit_if: ALU flag inputs, flag write mask, condition code, LIFO controls (master drives) and flags/cin/cond_true/depth/full/empty/errors (slave drives).
interface psw_flag_unit_if #(parameter int STACK_DEPTH = 4);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  logic alu_n, alu_z, alu_c, alu_v;
  logic [3:0] flag_we, cond;
  logic push, pop, err_clr;
  logic [3:0] flags;
  logic cin, cond_true;
  logic [CNT_W-1:0] depth;
  logic full, empty, ovf_err, unf_err;
  modport master (
    output alu_n, alu_z, alu_c, alu_v, flag_we, cond, push, pop, err_clr,
    input flags, cin, cond_true, depth, full, empty, ovf_err, unf_err
  );
  modport slave (
    input alu_n, alu_z, alu_c, alu_v, flag_we, cond, push, pop, err_clr,
    output flags, cin, cond_true, depth, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational branch-condition evaluation; flags_i {N,Z,C,V} and cond_i in, cond_true_o out.
module cond_eval
  import psw_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       cond_true_o
);
  logic n, z, c, v;
  assign n = flags_i[FLG_N];
  assign z = flags_i[FLG_Z];
  assign c = flags_i[FLG_C];
  assign v = flags_i[FLG_V];
  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_true_o = z;
      COND_NE: cond_true_o = ~z;
      COND_CS: cond_true_o = c;
      COND_CC: cond_true_o = ~c;
      COND_MI: cond_true_o = n;
      COND_PL: cond_true_o = ~n;
      COND_VS: cond_true_o = v;
      COND_VC: cond_true_o = ~v;
      COND_HI: cond_true_o = c & ~z;
      COND_LS: cond_true_o = ~c | z;
      COND_GE: cond_true_o = n ~^ v;
      COND_LT: cond_true_o = n ^ v;
      COND_GT: cond_true_o = ~z & (n ~^ v);
      COND_LE: cond_true_o = z | (n ^ v);
      COND_AL: cond_true_o = 1'b1;
      COND_NV: cond_true_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/psw_flag_unit.sv
// psw_flag_unit: masked NZCV register with carry feedback, condition evaluation and a flag-save LIFO built only under PSW_FLAG_STACK_EN; ports clk, rst_n, bus (psw_flag_unit_if.slave).
module psw_flag_unit
  import psw_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  psw_flag_unit_if.slave bus
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  logic [3:0] flags_q, flags_d, alu_f, wr_f;
  assign alu_f = {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
  assign wr_f = (alu_f & bus.flag_we) | (flags_q & ~bus.flag_we);
`ifdef PSW_FLAG_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);
  logic [3:0] stk_q [STACK_DEPTH];
  logic [CNT_W-1:0] depth_q, depth_d;
  logic ovf_q, unf_q, ovf_d, unf_d, full, empty, do_push, do_pop;
  assign full = depth_q == CNT_W'(STACK_DEPTH);
  assign empty = depth_q == '0;
  assign do_push = bus.push & ~bus.pop & ~full;
  assign do_pop = bus.pop & ~bus.push & ~empty;
  assign ovf_d = (bus.push & ~bus.pop & full) | (ovf_q & ~bus.err_clr);
  assign unf_d = (bus.pop & ~bus.push & empty) | (unf_q & ~bus.err_clr);
  assign depth_d = do_push ? depth_q + 1'b1 : do_pop ? depth_q - 1'b1 : depth_q;
  assign flags_d = do_pop ? stk_q[IDX_W'(depth_q - 1'b1)] : wr_f;
  always_ff @(posedge clk)
    if (do_push) stk_q[depth_q[IDX_W-1:0]] <= flags_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      depth_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign bus.depth = depth_q;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;
`else
  logic unused_stk;
  assign unused_stk = bus.push ^ bus.pop ^ bus.err_clr;
  assign flags_d = wr_f;
  assign bus.depth = '0;
  assign bus.full = 1'b0;
  assign bus.empty = 1'b1;
  assign bus.ovf_err = 1'b0;
  assign bus.unf_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags_q <= '0;
    else flags_q <= flags_d;
  assign bus.flags = flags_q;
  assign bus.cin = flags_q[FLG_C];
  cond_eval u_cond (
    .flags_i(flags_q),
    .cond_i(bus.cond),
    .cond_true_o(bus.cond_true)
  );
endmodule
